// File: rtl/ann_mac_sequencer.sv
// Per-layer input sequencer: walks input indices, fetches each from memory and pulses one MAC accumulate per index.
// Optional watchdog on mem_valid is enabled by defining ANN_SEQ_TIMEOUT_EN.
module ann_mac_sequencer #(
  parameter int MAX_IN      = 16,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] max_input,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DATA = 3'd3,
    ACCUM     = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_IN_W = ADDR_W'(MAX_IN);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, lim, addr_q;
  logic              error_q;
  logic              illegal;
  logic              last_idx;
  logic              timeout_hit;

  assign illegal  = (max_input == '0) || (max_input > MAX_IN_W);
  assign last_idx = (idx == lim - ADDR_W'(1));

`ifdef ANN_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd;

  // Counter is zeroed in ISSUE so it always starts fresh on entry to WAIT_DATA.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd <= '0;
    end else if (state == ISSUE) begin
      wd <= '0;
    end else if (state == WAIT_DATA && !mem_valid) begin
      wd <= wd + WD_W'(1);
    end
  end

  assign timeout_hit = (state == WAIT_DATA) && !mem_valid && (wd == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Memory handshake: mem_req is a one-cycle request for mem_addr; the sequencer then
  // holds mem_addr and waits in WAIT_DATA for mem_valid, so at most one read is outstanding.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = illegal ? FINISH : CLEAR;
      CLEAR:     state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_DATA;
      WAIT_DATA: begin
        if (mem_valid)        state_nx = ACCUM;
        else if (timeout_hit) state_nx = FINISH;
      end
      ACCUM:     state_nx = last_idx ? FINISH : ISSUE;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      idx     <= '0;
      lim     <= '0;
      addr_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            lim     <= max_input;
            idx     <= '0;
            error_q <= illegal;
          end
        end
        ISSUE:     addr_q <= idx;
        WAIT_DATA: if (timeout_hit) error_q <= 1'b1;
        ACCUM:     if (!last_idx) idx <= idx + ADDR_W'(1);
        default:   ;
      endcase
    end
  end

  // addr_q keeps the last requested index visible while not fetching.
  assign mem_addr  = (state == ISSUE) ? idx : addr_q;
  assign mem_req   = (state == ISSUE);
  assign mac_clear = (state == CLEAR);
  assign mac_en    = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign error     = error_q;

endmodule
